// File: rtl/timer_ctrl_fsm.sv
// Front-panel sequencer for the MM:SS lab timer: button debounce, mode FSM
// (set/run/pause/alarm), one-cycle command strobes and digit blink masks.
module timer_ctrl_fsm #(
  parameter int DEB_CYCLES = 270000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       zero_flag,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_clear,
  output logic       cnt_en,
  output logic       clr_cnt,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [3:0] blink_mask,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_MIN = 3'd1,
    S_SET_SEC = 3'd2,
    S_RUN     = 3'd3,
    S_PAUSE   = 3'd4,
    S_ALARM   = 3'd5
  } state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  // Button lanes: 0 start, 1 mode, 2 up, 3 clear
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    press;
  logic [DW-1:0] deb_cnt [4];

  state_t        st;
  logic          blink_phase;
  logic [AW-1:0] alarm_cnt;

  logic ev_clear;
  logic ev_start;
  logic ev_mode;
  logic ev_up;

  assign raw = {btn_clear, btn_up, btn_mode, btn_start};

  // A lane's level flips only after DEB_CYCLES consecutive differing samples;
  // press fires on the 0->1 flip, so releases never produce an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          level[i]   <= sync2[i];
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Only the highest-priority event of a cycle survives: clear > start > mode > up.
  assign ev_clear = press[3];
  assign ev_start = press[0] & ~press[3];
  assign ev_mode  = press[1] & ~press[0] & ~press[3];
  assign ev_up    = press[2] & ~press[1] & ~press[0] & ~press[3];

  // Every state change also clears blink_phase, overriding the tick toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      cnt_en      <= 1'b0;
      clr_cnt     <= 1'b0;
      inc_min     <= 1'b0;
      inc_sec     <= 1'b0;
      blink_phase <= 1'b0;
      alarm_cnt   <= '0;
    end else begin
      cnt_en  <= 1'b0;
      clr_cnt <= 1'b0;
      inc_min <= 1'b0;
      inc_sec <= 1'b0;
      if (tick_1hz) blink_phase <= ~blink_phase;

      if (ev_clear) begin
        clr_cnt     <= 1'b1;
        st          <= S_IDLE;
        blink_phase <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (ev_start && !zero_flag) begin
              st          <= S_RUN;
              blink_phase <= 1'b0;
            end else if (ev_mode) begin
              st          <= S_SET_MIN;
              blink_phase <= 1'b0;
            end
          end
          S_SET_MIN: begin
            if (ev_start) begin
              st          <= zero_flag ? S_IDLE : S_RUN;
              blink_phase <= 1'b0;
            end else if (ev_mode) begin
              st          <= S_SET_SEC;
              blink_phase <= 1'b0;
            end else if (ev_up) begin
              inc_min <= 1'b1;
            end
          end
          S_SET_SEC: begin
            if (ev_start) begin
              st          <= zero_flag ? S_IDLE : S_RUN;
              blink_phase <= 1'b0;
            end else if (ev_mode) begin
              st          <= S_IDLE;
              blink_phase <= 1'b0;
            end else if (ev_up) begin
              inc_sec <= 1'b1;
            end
          end
          S_RUN: begin
            if (ev_start) begin
              st          <= S_PAUSE;
              blink_phase <= 1'b0;
            end else if (zero_flag) begin
              st          <= S_ALARM;
              blink_phase <= 1'b0;
              alarm_cnt   <= '0;
            end else if (tick_1hz) begin
              cnt_en <= 1'b1;
            end
          end
          S_PAUSE: begin
            if (ev_start) begin
              st          <= S_RUN;
              blink_phase <= 1'b0;
            end else if (ev_mode) begin
              st          <= S_SET_MIN;
              blink_phase <= 1'b0;
            end
          end
          S_ALARM: begin
            if (ev_start || ev_mode || ev_up) begin
              st          <= S_IDLE;
              blink_phase <= 1'b0;
            end else if (tick_1hz) begin
              if (alarm_cnt == ALARM_LAST) begin
                st          <= S_IDLE;
                blink_phase <= 1'b0;
              end else begin
                alarm_cnt <= alarm_cnt + AW'(1);
              end
            end
          end
          default: begin
            st          <= S_IDLE;
            blink_phase <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st;
  assign alarm = (st == S_ALARM);

  always_comb begin
    blink_mask = 4'b0000;
    if (blink_phase) begin
      case (st)
        S_SET_MIN:        blink_mask = 4'b1100;
        S_SET_SEC:        blink_mask = 4'b0011;
        S_PAUSE, S_ALARM: blink_mask = 4'b1111;
        default:          blink_mask = 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Directed bench for timer_ctrl_fsm with DEB_CYCLES=4, ALARM_SECS=3.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_timer_ctrl_fsm;
  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       zero_flag;
  logic       btn_start;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_clear;
  logic       cnt_en;
  logic       clr_cnt;
  logic       inc_min;
  logic       inc_sec;
  logic [3:0] blink_mask;
  logic       alarm;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int n_cnt = 0;
  int n_clr = 0;
  int n_min = 0;
  int n_sec = 0;
  int c0;
  int m0;
  int s0;
  logic [3:0] exp_q[$];

  timer_ctrl_fsm #(.DEB_CYCLES(4), .ALARM_SECS(3)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .zero_flag(zero_flag),
    .btn_start(btn_start), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_clear(btn_clear), .cnt_en(cnt_en), .clr_cnt(clr_cnt),
    .inc_min(inc_min), .inc_sec(inc_sec), .blink_mask(blink_mask),
    .alarm(alarm), .state(state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Strobe counters sampled on the falling edge: a pulse wider than one
  // cycle is counted more than once.
  always @(negedge clk) begin
    if (cnt_en)  n_cnt++;
    if (clr_cnt) n_clr++;
    if (inc_min) n_min++;
    if (inc_sec) n_sec++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_start = v;
      1: btn_mode  = v;
      2: btn_up    = v;
      default: btn_clear = v;
    endcase
  endtask

  // Held press: after 2 sync + 4 debounce + 1 register cycles the effect is visible.
  task automatic push(input int b);
    set_btn(b, 1'b1);
    step(7);
  endtask

  task automatic release_btn(input int b);
    set_btn(b, 1'b0);
    step(7);
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; zero_flag = 1'b0;
    btn_start = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_clear = 1'b0;
    step(2);
    check("rst_state", state, 0);
    check("rst_strobes", {cnt_en, clr_cnt, inc_min, inc_sec}, 0);
    check("rst_mask", blink_mask, 0);
    check("rst_alarm", alarm, 0);
    rst = 1'b0;
    step(2);

    // Bouncy start: only the final stable high is debounced
    btn_start = 1'b1; step(1); btn_start = 1'b0; step(1);
    btn_start = 1'b1; step(1); btn_start = 1'b0; step(1);
    btn_start = 1'b1;
    step(6);
    check("bounce_pre", state, 0);
    step(1);
    check("bounce_run", state, 3);
    step(20);
    check("bounce_hold", state, 3);
    btn_start = 1'b0;
    step(7);
    check("release_no_event", state, 3);

    c0 = n_clr;
    push(3);
    check("clr_strobe", clr_cnt, 1);
    check("clr_state", state, 0);
    release_btn(3);
    check("clr_count", n_clr - c0, 1);

    // Set minutes and seconds
    m0 = n_min; s0 = n_sec;
    push(1);
    check("set_min_state", state, 1);
    check("set_min_mask0", blink_mask, 0);
    release_btn(1);
    for (int i = 0; i < 3; i++) begin
      push(2);
      check("inc_min_pulse", inc_min, 1);
      release_btn(2);
    end
    check("inc_min_count", n_min - m0, 3);
    check("inc_sec_none", n_sec - s0, 0);
    tick_once();
    check("mask_min", blink_mask, 4'b1100);
    push(1);
    check("set_sec_state", state, 2);
    check("set_sec_mask0", blink_mask, 0);
    release_btn(1);
    tick_once();
    check("mask_sec", blink_mask, 4'b0011);
    for (int i = 0; i < 2; i++) begin
      push(2);
      release_btn(2);
    end
    check("inc_sec_count", n_sec - s0, 2);
    check("inc_min_hold", n_min - m0, 3);
    push(1);
    check("set_sec_to_idle", state, 0);
    release_btn(1);

    // RUN: five ticks, each answered by one cnt_en the next cycle
    push(0);
    check("idle_to_run", state, 3);
    release_btn(0);
    c0 = n_cnt;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0000);
    end
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) tick_once();
      else step(1);
      check("run_strobe", {cnt_en, clr_cnt, inc_min, inc_sec}, exp_q.pop_front());
    end
    check("run_cnt_count", n_cnt - c0, 5);
    check("run_mask", blink_mask, 0);
    btn_start = 1'b1;
    step(6);
    tick_once();
    check("pause_state", state, 4);
    check("pause_no_cnt", cnt_en, 0);
    btn_start = 1'b0;
    step(7);
    check("pause_cnt_count", n_cnt - c0, 5);
    tick_once();
    check("pause_mask_on", blink_mask, 4'b1111);
    step(1);
    tick_once();
    check("pause_mask_off", blink_mask, 4'b0000);
    step(2);
    check("pause_ticks_ignored", n_cnt - c0, 5);

    // Clear and start together in PAUSE
    c0 = n_clr;
    btn_clear = 1'b1; btn_start = 1'b1;
    step(7);
    check("clr_start_strobe", clr_cnt, 1);
    check("clr_start_state", state, 0);
    btn_clear = 1'b0; btn_start = 1'b0;
    step(7);
    check("clr_start_count", n_clr - c0, 1);
    check("clr_start_idle", state, 0);

    // ALARM via zero_flag, then timeout after 3 ticks
    push(0);
    release_btn(0);
    check("run_again", state, 3);
    c0 = n_cnt;
    zero_flag = 1'b1;
    tick_once();
    check("alarm_entry", state, 5);
    check("alarm_flag", alarm, 1);
    check("alarm_no_cnt", cnt_en, 0);
    step(1);
    tick_once();
    check("alarm_mask", blink_mask, 4'b1111);
    step(1);
    tick_once();
    check("alarm_hold", state, 5);
    step(1);
    tick_once();
    check("alarm_timeout", state, 0);
    check("alarm_clear", alarm, 0);
    check("alarm_cnt_none", n_cnt - c0, 0);
    push(0);
    check("idle_zero_start", state, 0);
    release_btn(0);

    // ALARM exited by an up press, which must not increment anything
    zero_flag = 1'b0;
    push(0);
    release_btn(0);
    check("run_third", state, 3);
    zero_flag = 1'b1;
    step(1);
    check("alarm_again", state, 5);
    zero_flag = 1'b0;
    m0 = n_min; s0 = n_sec;
    push(2);
    check("alarm_up_exit", state, 0);
    release_btn(2);
    check("alarm_up_no_min", n_min - m0, 0);
    check("alarm_up_no_sec", n_sec - s0, 0);

    // Asynchronous reset in RUN with a mode press mid-debounce
    push(0);
    release_btn(0);
    check("run_fourth", state, 3);
    btn_mode = 1'b1;
    step(3);
    tick_once();
    check("pre_rst_cnt", cnt_en, 1);
    rst = 1'b1;
    #2;
    check("async_rst_state", state, 0);
    check("async_rst_strobes", {cnt_en, clr_cnt, inc_min, inc_sec}, 0);
    check("async_rst_alarm", alarm, 0);
    check("async_rst_mask", blink_mask, 0);
    step(2);
    rst = 1'b0;
    step(6);
    check("post_rst_deb_pre", state, 0);
    step(1);
    check("post_rst_mode", state, 1);
    btn_mode = 1'b0;
    step(7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
